// File: rtl/uart_pkg.sv
// Shared UART timing definitions: FSM state encoding, default divisor
// constants and oversample-ratio legality helpers.
package uart_pkg;

    // Run/idle state of the baud tick generator.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Divisor in effect after reset (clocks per oversample tick).
    localparam int DEF_INT_C  = 163;
    localparam int DEF_FRAC_C = 0;

    // Supported oversample ratios.
    localparam int OVS_MIN = 4;
    localparam int OVS_MAX = 64;

    // True when ovs is a power of two between OVS_MIN and OVS_MAX.
    function automatic bit ovs_is_legal(input int ovs);
        return (ovs >= OVS_MIN) && (ovs <= OVS_MAX) && ((ovs & (ovs - 1)) == 0);
    endfunction

    // Width of the oversample phase index. An illegal ratio yields a zero
    // width, which makes the phase port ill-formed and stops elaboration.
    function automatic int ovs_phase_w(input int ovs);
        if (ovs_is_legal(ovs)) begin
            return $clog2(ovs);
        end else begin
            return 0;
        end
    endfunction

endpackage : uart_pkg

// File: rtl/baud_tick_gen_frac_accum.sv
// Fractional phase accumulator: holds a FRAC_W-bit running sum of the
// fractional divisor and exposes the carry that the next add would produce.
module frac_accum #(
    parameter int FRAC_W = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic [FRAC_W:0]   sum_s;

    // Sum of the held phase and the fractional divisor; the top bit is the carry.
    always_comb begin
        sum_s   = {1'b0, acc_q} + {1'b0, frac_i};
        carry_o = sum_s[FRAC_W];
    end

    // Next accumulator value: clear wins over step, otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = {FRAC_W{1'b0}};
        end else if (step) begin
            acc_d = sum_s[FRAC_W-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register, cleared immediately on reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            acc_q <= {FRAC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : frac_accum

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: produces oversample ticks every
// div_int + div_frac/2^FRAC_W clocks on average, plus bit-boundary and
// mid-bit strobes. The divisor is double-buffered so a reload never cuts
// a period short, and a sync strobe realigns the bit phase to an RX edge.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = DEF_INT_C,
    parameter int DEF_FRAC = DEF_FRAC_C
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CNT_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          sync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic                          bit_mid,
    output logic [ovs_phase_w(OVS)-1:0]   os_phase,
    output logic                          div_err
);

    localparam int PH_W = ovs_phase_w(OVS);

    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MIN_DIV    = CNT_W'(2);
    localparam logic [CNT_W-1:0]  RST_INT    = CNT_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC   = FRAC_W'(DEF_FRAC);
    localparam logic [PH_W-1:0]   PH_ZERO    = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]   PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]   PH_PRE_MID = PH_W'(OVS / 2 - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              bit_mid_q, bit_mid_d;
    logic              div_err_q, div_err_d;
    logic [CNT_W-1:0]  shadow_int_q, shadow_int_d;
    logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
    logic [CNT_W-1:0]  active_int_q, active_int_d;
    logic [FRAC_W-1:0] active_frac_q, active_frac_d;

    logic              adopt_s;
    logic              acc_clr_s;
    logic              acc_step_s;
    logic              acc_carry_s;
    logic [CNT_W-1:0]  period_m1_s;
    logic [CNT_W-1:0]  restart_m1_s;

    // Shadow divisor capture with clamping of divisors too small to count.
    always_comb begin
        shadow_int_d  = shadow_int_q;
        shadow_frac_d = shadow_frac_q;
        div_err_d     = div_err_q;
        if (div_load) begin
            shadow_frac_d = div_frac;
            if (div_int < MIN_DIV) begin
                shadow_int_d = MIN_DIV;
                div_err_d    = 1'b1;
            end else begin
                shadow_int_d = div_int;
            end
        end else begin
            shadow_int_d  = shadow_int_q;
            shadow_frac_d = shadow_frac_q;
        end
    end

    // Decide when the shadow divisor becomes active: always while idle,
    // otherwise only at a period boundary (tick reload or sync restart).
    // The shadow's next value is used so a coincident load takes effect.
    always_comb begin
        adopt_s = 1'b0;
        case (state_q)
            ST_IDLE: adopt_s = 1'b1;
            ST_RUN: begin
                if (en && (sync || (cnt_q == CNT_ZERO))) begin
                    adopt_s = 1'b1;
                end else begin
                    adopt_s = 1'b0;
                end
            end
            default: adopt_s = 1'b1;
        endcase
        if (adopt_s) begin
            active_int_d  = shadow_int_d;
            active_frac_d = shadow_frac_d;
        end else begin
            active_int_d  = active_int_q;
            active_frac_d = active_frac_q;
        end
    end

    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .clock   (clock),
        .rst     (rst),
        .clr     (acc_clr_s),
        .step    (acc_step_s),
        .frac_i  (active_frac_d),
        .carry_o (acc_carry_s)
    );

    // Counter reload values: a normal period stretches by one clock on a
    // fractional carry; a sync restart always uses the bare integer divisor.
    always_comb begin
        if (acc_carry_s) begin
            period_m1_s = active_int_d;
        end else begin
            period_m1_s = active_int_d - CNT_ONE;
        end
        restart_m1_s = active_int_d - CNT_ONE;
    end

    // Run/idle FSM, period down-counter, phase index and tick generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        bit_mid_d  = 1'b0;
        acc_clr_s  = 1'b0;
        acc_step_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = CNT_ZERO;
                phase_d = PH_ZERO;
                if (en) begin
                    state_d    = ST_RUN;
                    cnt_d      = period_m1_s;
                    acc_step_s = 1'b1;
                end else begin
                    acc_clr_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    phase_d   = PH_ZERO;
                    acc_clr_s = 1'b1;
                end else if (sync) begin
                    cnt_d     = restart_m1_s;
                    phase_d   = PH_ZERO;
                    acc_clr_s = 1'b1;
                end else if (cnt_q == CNT_ZERO) begin
                    os_tick_d  = 1'b1;
                    bit_tick_d = (phase_q == PH_LAST);
                    bit_mid_d  = (phase_q == PH_PRE_MID);
                    phase_d    = phase_q + PH_ONE;
                    cnt_d      = period_m1_s;
                    acc_step_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                phase_d   = PH_ZERO;
                acc_clr_s = 1'b1;
            end
        endcase
    end

    // State, divisor and output registers; reset aborts any running period.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            phase_q       <= PH_ZERO;
            os_tick_q     <= 1'b0;
            bit_tick_q    <= 1'b0;
            bit_mid_q     <= 1'b0;
            div_err_q     <= 1'b0;
            shadow_int_q  <= RST_INT;
            shadow_frac_q <= RST_FRAC;
            active_int_q  <= RST_INT;
            active_frac_q <= RST_FRAC;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            os_tick_q     <= os_tick_d;
            bit_tick_q    <= bit_tick_d;
            bit_mid_q     <= bit_mid_d;
            div_err_q     <= div_err_d;
            shadow_int_q  <= shadow_int_d;
            shadow_frac_q <= shadow_frac_d;
            active_int_q  <= active_int_d;
            active_frac_q <= active_frac_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign bit_mid  = bit_mid_q;
    assign os_phase = phase_q;
    assign div_err  = div_err_q;

endmodule : baud_tick_gen
